// File: rtl/comb_pkg.sv
// Shared definitions for the multi-channel combiner: operation encoding.
package comb_pkg;

  localparam int unsigned OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_XOR = 2'd0,
    OP_AND = 2'd1,
    OP_OR  = 2'd2,
    OP_ADD = 2'd3
  } op_e;

endpackage

// File: rtl/chan_fifo.sv
// Per-channel synchronous FIFO: one word in, one word out per cycle,
// occupancy reported as fill. Push is ignored when full, pop when empty.
module chan_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];
  assign fill    = count;

  // Storage write and pointer/occupancy bookkeeping; pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/multi_chan_combiner.sv
// NCH buffered input streams combined word-by-word into one registered
// output under a run-time selectable XOR/AND/OR/ADD fold.
module multi_chan_combiner
  import comb_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NCH*WIDTH-1:0]                in_data,
  input  logic [NCH-1:0]                      in_enable,
  output logic [NCH-1:0]                      in_ready,
  input  logic [OP_W-1:0]                     op_mode,
  output logic [WIDTH-1:0]                    Y_data,
  output logic                                Y_enable,
  input  logic                                Y_ready,
  output logic [NCH*($clog2(DEPTH)+1)-1:0]    fill
);

  localparam int unsigned FW = $clog2(DEPTH) + 1;

  logic [NCH-1:0]            empty;
  logic [NCH-1:0]            full;
  logic [NCH-1:0][WIDTH-1:0] heads;
  logic                      fire;
  logic                      y_enable_q;
  logic [WIDTH-1:0]          y_data_q;
  logic [WIDTH-1:0]          result;
  op_e                       op_sel;

  assign op_sel = op_e'(op_mode);

  // All channels pop together; the output slot is free when empty or draining.
  assign fire = ~|empty & (~y_enable_q | Y_ready);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    chan_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (in_enable[i]),
      .push_data (in_data[i*WIDTH +: WIDTH]),
      .pop       (fire),
      .head      (heads[i]),
      .empty     (empty[i]),
      .full      (full[i]),
      .fill      (fill[i*FW +: FW])
    );
    // Ready is purely occupancy-based so Y_ready never reaches in_ready.
    assign in_ready[i] = ~full[i] & ~reset;
  end

  // Fold all channel heads with the selected operation; ADD drops the carry.
  always_comb begin
    result = heads[0];
    for (int unsigned i = 1; i < NCH; i++) begin
      case (op_sel)
        OP_XOR:  result = result ^ heads[i];
        OP_AND:  result = result & heads[i];
        OP_OR:   result = result | heads[i];
        OP_ADD:  result = result + heads[i];
        default: result = result;
      endcase
    end
  end

  // Output register: load on fire, release once the consumer takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      y_enable_q <= 1'b0;
      y_data_q   <= '0;
    end else if (fire) begin
      y_enable_q <= 1'b1;
      y_data_q   <= result;
    end else if (Y_ready) begin
      y_enable_q <= 1'b0;
    end
  end

  assign Y_enable = y_enable_q;
  assign Y_data   = y_data_q;

endmodule
